pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the 16-bit five-stage pipeline; it sequences the IF/ID register, the PC and the downstream stage registers. It arbitrates the single shared RAM between instruction fetch and MEM-stage data access, detects load-use hazards, applies branch flushes, and counts stall cycles for debug. It sits beside the pipeline registers and drives their hold and flush inputs directly.

## Interface
- MEM_WAIT, 1, RAM cycles per data access; legal range 1..8.
- CNT_W, 16, width of the stall counter.

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- mem_req  in  1  MEM stage needs RAM; held high until mem_done
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  4  EX load destination code; 4'hF = none
- id_rs, id_rt  in  4 each  ID-stage source register codes; 4'hF = unused
- branch_taken  in  1  EX resolved a taken branch or jump; PC loads target when pc_hold=0
- fetch_grant  out  1  RAM bus owned by instruction fetch
- mem_grant  out  1  RAM bus owned by MEM stage
- mem_done  out  1  one-cycle pulse on the final data-access cycle
- pc_hold  out  1  PC keeps its value
- if_hold  out  1  IF/ID keeps its contents
- if_flush  out  1  IF/ID loads NOP (16'h0800) and PC 0
- id_ex_bubble  out  1  ID/EX loads a bubble
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB
- stall_count  out  CNT_W  saturating count of cycles with pc_hold=1

## Operation
- States: FETCH, DATA. A 3-bit wait counter `wcnt` is active in DATA.
- load_use = ex_mem_read & ex_rd!=4'hF & (ex_rd==id_rs | ex_rd==id_rt).
- FETCH with mem_req=1 (request cycle): pipe_hold=1, pc_hold=1, if_hold=1, fetch_grant=1. branch_taken and load_use are ignored because EX is frozen and the conditions re-present later. Next state is DATA, with wcnt=MEM_WAIT-1.
- FETCH with mem_req=0: fetch_grant=1, evaluated in priority order:
  - branch_taken: if_flush=1, pc_hold=0.
  - else load_use: pc_hold=1, if_hold=1, id_ex_bubble=1.
  - else all controls 0.
- DATA: mem_grant=1, fetch_grant=0.
  - wcnt!=0: pipe_hold=1, pc_hold=1, if_hold=1; wcnt decrements.
  - wcnt==0 (last cycle): mem_done=1, pipe_hold=0, next state FETCH. Priority for this cycle:
    - branch_taken: if_flush=1, pc_hold=0.
    - else load_use: pc_hold=1, if_hold=1, id_ex_bubble=1.
    - else if_flush=1, pc_hold=1, because the fetch slot was lost.
- mem_req falling inside DATA is a protocol violation. The access still completes its count.
- mem_req still high in the cycle after mem_done is a new request.
- if_hold and if_flush are never both 1; if_flush wins by construction.
- stall_count increments on every clk edge where pc_hold=1 and saturates at all-ones.

## Timing
- All outputs except stall_count are combinational from state, wcnt and inputs; state, wcnt and stall_count are registered.
- Reset (rst=0, asynchronous, any state including mid-DATA): state=FETCH, wcnt=0, stall_count=0. With mem_req=0 and branch_taken=0 the outputs are fetch_grant=1 and all others 0. Any access in progress is abandoned.
- Data-access latency: mem_req rising in FETCH gives mem_grant MEM_WAIT cycles later, then mem_done in the last of those cycles.
  - Total MEM_WAIT+1 cycles from request to release, with PC held throughout.
- Load-use stall: 1 cycle per occurrence. Branch flush: 1 cycle.

## Structure
- Shared package pipeline_pkg holds:
  - state enum {FETCH, DATA}
  - REG_NONE = 4'hF
  - NOP_INST = 16'h0800, which IF/ID also uses.
- Sub-module hazard_unit: purely combinational load_use comparison, reused by the forwarding logic later.
- FSM, wait counter and stall counter live in pipeline_ctrl.

## Test plan
- Reset values: rst low mid-DATA with MEM_WAIT=3 -> FETCH immediately, stall_count=0, fetch_grant=1, mem_grant=0.
- Load-use: ex_mem_read=1, ex_rd=4'h2, id_rs=4'h2 -> exactly one cycle of pc_hold=if_hold=id_ex_bubble=1; stall_count=1.
- Data access, MEM_WAIT=1: one mem_req cycle ->
  - cycle0 pipe_hold=1
  - cycle1 mem_grant=1, mem_done=1, if_flush=1, pc_hold=1
  - cycle2 fetch_grant=1
  - stall_count=2.
- Data access, MEM_WAIT=3: mem_grant high 3 cycles, pipe_hold high in the request cycle plus 2, mem_done only in the 3rd DATA cycle.
- Branch on last DATA cycle: branch_taken=1 with wcnt==0 -> if_flush=1, pc_hold=0, id_ex_bubble=0 even with load_use=1.
- Saturation: force 70000 held cycles with CNT_W=16 -> stall_count stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller states, register code sentinel, NOP encoding.
package pipeline_pkg;

   // RAM bus owner phase of the stall/flush controller
   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } state_t;

   // Register code meaning "no register"
   localparam logic [3:0]  REG_NONE = 4'hF;

   // Instruction loaded into IF/ID on a flush
   localparam logic [15:0] NOP_INST = 16'h0800;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect: a load in EX writes a register the ID instruction reads.
module hazard_unit
   import pipeline_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [3:0] ex_rd,
   input  logic [3:0] id_rs,
   input  logic [3:0] id_rt,
   output logic       load_use
);

   // REG_NONE on ex_rd never matches, even if a source is also REG_NONE
   always_comb begin
      load_use = ex_mem_read && (ex_rd != REG_NONE) &&
                 ((ex_rd == id_rs) || (ex_rd == id_rt));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: shares the single RAM between fetch and MEM,
// inserts load-use bubbles, applies branch flushes, counts PC-held cycles.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_WAIT = 1,   // RAM cycles per data access, 1..8
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_req,
   input  logic             ex_mem_read,
   input  logic [3:0]       ex_rd,
   input  logic [3:0]       id_rs,
   input  logic [3:0]       id_rt,
   input  logic             branch_taken,
   output logic             fetch_grant,
   output logic             mem_grant,
   output logic             mem_done,
   output logic             pc_hold,
   output logic             if_hold,
   output logic             if_flush,
   output logic             id_ex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

   state_t     state, state_nxt;
   logic [2:0] wcnt, wcnt_nxt;
   logic       load_use;

   hazard_unit u_hazard (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .load_use    (load_use)
   );

   // State and wait counter; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
         wcnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // Next state and combinational pipeline controls
   always_comb begin
      fetch_grant  = 1'b0;
      mem_grant    = 1'b0;
      mem_done     = 1'b0;
      pc_hold      = 1'b0;
      if_hold      = 1'b0;
      if_flush     = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
      state_nxt    = state;
      wcnt_nxt     = wcnt;
      case (state)
         FETCH: begin
            fetch_grant = 1'b1;
            if (mem_req) begin
               // Whole pipe frozen; branch/load-use re-present after the access
               pipe_hold = 1'b1;
               pc_hold   = 1'b1;
               if_hold   = 1'b1;
               state_nxt = DATA;
               wcnt_nxt  = WAIT_INIT;
            end else if (branch_taken) begin
               if_flush = 1'b1;
            end else if (load_use) begin
               pc_hold      = 1'b1;
               if_hold      = 1'b1;
               id_ex_bubble = 1'b1;
            end
         end
         DATA: begin
            // mem_req is not sampled here: a dropped request still runs out its count
            mem_grant = 1'b1;
            if (wcnt != 3'd0) begin
               pipe_hold = 1'b1;
               pc_hold   = 1'b1;
               if_hold   = 1'b1;
               wcnt_nxt  = wcnt - 3'd1;
            end else begin
               mem_done  = 1'b1;
               state_nxt = FETCH;
               if (branch_taken) begin
                  if_flush = 1'b1;
               end else if (load_use) begin
                  pc_hold      = 1'b1;
                  if_hold      = 1'b1;
                  id_ex_bubble = 1'b1;
               end else begin
                  // Fetch slot went to the data access: refetch the same PC
                  if_flush = 1'b1;
                  pc_hold  = 1'b1;
               end
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Saturating count of cycles with the PC held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if (pc_hold && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: two instances (MEM_WAIT=1 and 3) with shared
// hazard/branch inputs and private mem_req; expectations queued per step.
module tb_pipeline_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req1, mem_req3;
   logic        ex_mem_read, branch_taken;
   logic [3:0]  ex_rd, id_rs, id_rt;

   logic        fg1, mg1, md1, ph1, ih1, fl1, bb1, pj1;
   logic        fg3, mg3, md3, ph3, ih3, fl3, bb3, pj3;
   logic [15:0] sc1, sc3;
   logic [7:0]  o1, o3;

   int errors = 0;
   int checks = 0;

   // {fetch_grant, mem_grant, mem_done, pc_hold, if_hold, if_flush, id_ex_bubble, pipe_hold}
   assign o1 = {fg1, mg1, md1, ph1, ih1, fl1, bb1, pj1};
   assign o3 = {fg3, mg3, md3, ph3, ih3, fl3, bb3, pj3};

   always #5 clk = ~clk;

   pipeline_ctrl #(.MEM_WAIT(1), .CNT_W(16)) u_d1 (
      .clk(clk), .rst(rst), .mem_req(mem_req1), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
      .fetch_grant(fg1), .mem_grant(mg1), .mem_done(md1), .pc_hold(ph1),
      .if_hold(ih1), .if_flush(fl1), .id_ex_bubble(bb1), .pipe_hold(pj1),
      .stall_count(sc1));

   pipeline_ctrl #(.MEM_WAIT(3), .CNT_W(16)) u_d3 (
      .clk(clk), .rst(rst), .mem_req(mem_req3), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
      .fetch_grant(fg3), .mem_grant(mg3), .mem_done(md3), .pc_hold(ph3),
      .if_hold(ih3), .if_flush(fl3), .id_ex_bubble(bb3), .pipe_hold(pj3),
      .stall_count(sc3));

   typedef struct {
      string       tag;
      logic [7:0]  o1, o3;
      logic [15:0] s1, s3;
      bit          c1, c3;
   } exp_t;

   exp_t sb[$];

   localparam logic [7:0] IDLE  = 8'b1000_0000;
   localparam logic [7:0] LU    = 8'b1001_1010;
   localparam logic [7:0] BR    = 8'b1000_0100;
   localparam logic [7:0] REQ   = 8'b1001_1001;
   localparam logic [7:0] WAITC = 8'b0101_1001;
   localparam logic [7:0] LAST  = 8'b0111_0100;
   localparam logic [7:0] LASTB = 8'b0110_0100;
   localparam logic [7:0] LASTL = 8'b0111_1010;

   // Advance to just after the next rising edge, where inputs are driven
   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(bit m1, bit m3, bit emr, logic [3:0] rd, logic [3:0] rs,
                         logic [3:0] rt, bit br);
      mem_req1 = m1; mem_req3 = m3; ex_mem_read = emr;
      ex_rd = rd; id_rs = rs; id_rt = rt; branch_taken = br;
   endtask

   // Queue the expectation for this step, then compare at the falling edge
   task automatic chk(string tag, logic [7:0] e1, logic [7:0] e3,
                      logic [15:0] s1, logic [15:0] s3, bit c1, bit c3);
      exp_t e;
      e.tag = tag; e.o1 = e1; e.o3 = e3; e.s1 = s1; e.s3 = s3; e.c1 = c1; e.c3 = c3;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      if (e.c1) begin
         checks++;
         assert (o1 === e.o1) else begin
            errors++; $error("FAIL %s d1 ctrl got %b want %b", e.tag, o1, e.o1);
         end
         checks++;
         assert (sc1 === e.s1) else begin
            errors++; $error("FAIL %s d1 stall_count got %0d want %0d", e.tag, sc1, e.s1);
         end
      end
      if (e.c3) begin
         checks++;
         assert (o3 === e.o3) else begin
            errors++; $error("FAIL %s d3 ctrl got %b want %b", e.tag, o3, e.o3);
         end
         checks++;
         assert (sc3 === e.s3) else begin
            errors++; $error("FAIL %s d3 stall_count got %0d want %0d", e.tag, sc3, e.s3);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0);
      chk("reset", IDLE, IDLE, 0, 0, 1, 1);
      go(); rst = 1'b1;
      chk("idle", IDLE, IDLE, 0, 0, 1, 1);

      // Load-use detection and its one-cycle stall
      go(); set_in(0, 0, 1, 4'h2, 4'h2, 4'hF, 0); chk("lu_rs", LU, LU, 0, 0, 1, 1);
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("lu_once", IDLE, IDLE, 1, 1, 1, 1);
      go(); set_in(0, 0, 1, 4'h5, 4'hF, 4'h5, 0); chk("lu_rt", LU, LU, 1, 1, 1, 1);
      go(); set_in(0, 0, 1, 4'hF, 4'hF, 4'hF, 0); chk("rd_none", IDLE, IDLE, 2, 2, 1, 1);
      go(); set_in(0, 0, 0, 4'h3, 4'h3, 4'hF, 0); chk("no_load", IDLE, IDLE, 2, 2, 1, 1);
      go(); set_in(0, 0, 1, 4'h3, 4'h3, 4'hF, 1); chk("br_over_lu", BR, BR, 2, 2, 1, 1);
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("br_once", IDLE, IDLE, 2, 2, 1, 1);

      // MEM_WAIT=1 access
      go(); set_in(1, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("w1_req", REQ, IDLE, 2, 2, 1, 1);
      go(); chk("w1_last", LAST, IDLE, 3, 2, 1, 1);
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("w1_rel", IDLE, IDLE, 4, 2, 1, 1);

      // MEM_WAIT=3 access
      go(); set_in(0, 1, 0, 4'hF, 4'hF, 4'hF, 0); chk("w3_req", IDLE, REQ, 4, 2, 1, 1);
      go(); chk("w3_d0", IDLE, WAITC, 4, 3, 1, 1);
      go(); chk("w3_d1", IDLE, WAITC, 4, 4, 1, 1);
      go(); chk("w3_last", IDLE, LAST, 4, 5, 1, 1);
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("w3_rel", IDLE, IDLE, 4, 6, 1, 1);

      // Branch beats load-use on the last DATA cycle; ignored in the request cycle
      go(); set_in(0, 1, 1, 4'h2, 4'h2, 4'hF, 1); chk("brl_req", BR, REQ, 4, 6, 1, 1);
      go(); set_in(0, 1, 1, 4'h2, 4'h2, 4'hF, 0); chk("brl_d0", LU, WAITC, 4, 7, 1, 1);
      go(); chk("brl_d1", LU, WAITC, 5, 8, 1, 1);
      go(); set_in(0, 1, 1, 4'h2, 4'h2, 4'hF, 1); chk("brl_last", BR, LASTB, 6, 9, 1, 1);
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("brl_rel", IDLE, IDLE, 6, 9, 1, 1);

      // Load-use on the last DATA cycle, then mem_req still high = new request
      go(); set_in(0, 1, 0, 4'hF, 4'hF, 4'hF, 0); chk("lul_req", IDLE, REQ, 6, 9, 1, 1);
      go(); chk("lul_d0", IDLE, WAITC, 6, 10, 1, 1);
      go(); chk("lul_d1", IDLE, WAITC, 6, 11, 1, 1);
      go(); set_in(0, 1, 1, 4'h7, 4'h7, 4'hF, 0); chk("lul_last", LU, LASTL, 6, 12, 1, 1);
      go(); set_in(0, 1, 0, 4'hF, 4'hF, 4'hF, 0); chk("b2b_req", IDLE, REQ, 7, 13, 1, 1);
      go(); chk("b2b_d0", IDLE, WAITC, 7, 14, 1, 1);
      // mem_req dropped mid-access: the count still completes
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("drop_d1", IDLE, WAITC, 7, 15, 1, 1);
      go(); chk("drop_last", IDLE, LAST, 7, 16, 1, 1);
      go(); chk("drop_rel", IDLE, IDLE, 7, 17, 1, 1);

      // Saturation: hold load-use so pc_hold stays high
      go(); set_in(0, 0, 1, 4'h2, 4'h2, 4'hF, 0); chk("sat_start", LU, LU, 7, 17, 1, 1);
      repeat (65517) @(posedge clk);
      chk("sat_edge", LU, LU, 0, 16'hFFFE, 0, 1);
      repeat (4500) @(posedge clk);
      chk("sat_hold", LU, LU, 16'hFFFF, 16'hFFFF, 1, 1);
      go(); set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0); chk("sat_idle", IDLE, IDLE, 16'hFFFF, 16'hFFFF, 1, 1);

      // Asynchronous reset in the middle of a DATA access
      go(); set_in(0, 1, 0, 4'hF, 4'hF, 4'hF, 0); chk("rst_req", IDLE, REQ, 16'hFFFF, 16'hFFFF, 1, 1);
      go(); rst = 1'b0; set_in(0, 0, 0, 4'hF, 4'hF, 4'hF, 0);
      chk("rst_mid", IDLE, IDLE, 0, 0, 1, 1);
      go(); chk("rst_held", IDLE, IDLE, 0, 0, 1, 1);
      go(); rst = 1'b1; chk("rst_rel", IDLE, IDLE, 0, 0, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
